modmul_bs_seq: RTL

Sequencer for the bit-serial modular multiplier datapath. It accepts a start request, loads the operands, and issues WIDTH bit-serial step enables. It then waits out the datapath's fixed pipeline latency (the LAT-stage delay line) and signals completion with a one-cycle done pulse. It sits between the host-side request interface and the bit-serial datapath.

---
 rtl/modmul_bs_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/modmul_bs_seq.sv
// Control sequencer for the bit-serial modular multiplier: load, WIDTH serial steps,
// LAT-cycle pipeline drain, then a single-cycle done pulse.
module modmul_bs_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 5,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          ld,
  output logic          bit_en,
  output logic          bit_first,
  output logic          bit_last,
  output logic [CW-1:0] bit_idx,
  output logic          done
);

  localparam int unsigned CntW      = ($clog2(LAT + 1) > CW) ? $clog2(LAT + 1) : CW;
  localparam int unsigned DrainLast = (LAT > 0) ? LAT - 1 : 0;
  localparam logic [CntW-1:0] StepLastC  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] DrainLastC = CntW'(DrainLast);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == StepLastC) begin
          state_d = (LAT > 0) ? StDrain : StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DrainLastC) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Abort is ignored here; a pending start re-launches with no idle bubble.
        cnt_d   = '0;
        state_d = start ? StLoad : StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs depend on registered state only, never on start/abort.
  always_comb begin
    busy      = (state_q == StLoad) || (state_q == StRun) || (state_q == StDrain);
    ld        = (state_q == StLoad);
    bit_en    = (state_q == StRun);
    bit_first = (state_q == StRun) && (cnt_q == '0);
    bit_last  = (state_q == StRun) && (cnt_q == StepLastC);
    bit_idx   = (state_q == StRun) ? cnt_q[CW-1:0] : '0;
    done      = (state_q == StDone);
  end

endmodule
